iob_fifo2axis: RTL and testbench

Read-side drain stage for `iob_fifo_sync`. It pops words from the FIFO read port, which has a 1-cycle read-data latency, and presents them on an AXI-Stream master interface. A 2-entry output buffer absorbs that latency, so the stream sustains one word per cycle. `tlast` is generated from a programmable packet length. The block sits directly downstream of the FIFO and upstream of any AXIS consumer (DMA, serializer, peripheral).

---
 rtl/iob_fifo2axis.sv | 89 ++++++++
 tb/tb_iob_fifo2axis.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo2axis.sv
// Drains a 1-cycle-latency FIFO read port into an AXI-Stream master.
// A two-word output buffer (obuf + sbuf) hides the read latency so the stream runs at one word per cycle.
module iob_fifo2axis #(
  parameter int DATA_W = 21,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              fifo_read_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_empty_i,
  output logic [DATA_W-1:0] axis_tdata_o,
  output logic              axis_tvalid_o,
  input  logic              axis_tready_i,
  output logic              axis_tlast_o,
  output logic [LEN_W-1:0]  word_cnt_o
);

  // Handshake: a word transfers on a cycle where tvalid and tready are both high;
  // tvalid, tdata and tlast stay fixed until that cycle, and tvalid never depends on tready.

  logic [1:0]        count_q, count_d;
  logic              pend_q, pend_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [DATA_W-1:0] obuf_q, obuf_d;
  logic [DATA_W-1:0] sbuf_q, sbuf_d;

  logic              pop;
  logic [1:0]        kept;
  logic [2:0]        occ;
  logic [LEN_W-1:0]  len_last;

  assign axis_tvalid_o = (count_q != 2'd0);
  assign axis_tdata_o  = obuf_q;
  assign len_last      = len_i - LEN_W'(1);
  assign axis_tlast_o  = axis_tvalid_o & (len_i != '0) & (wcnt_q == len_last);
  assign word_cnt_o    = wcnt_q;

  always_comb begin
    pop  = axis_tvalid_o & axis_tready_i;
    kept = count_q - {1'b0, pop};
    occ  = {1'b0, kept} + {2'b00, pend_q};
    // Occupancy after this cycle's pop, counting the word still in flight, must leave room.
    fifo_read_o = cke_i & ~rst_i & en_i & ~fifo_empty_i & (occ < 3'd2);
  end

  always_comb begin
    count_d = occ[1:0];
    pend_d  = fifo_read_o;
    obuf_d  = obuf_q;
    sbuf_d  = sbuf_q;
    wcnt_d  = wcnt_q;
    if (pop && (count_q == 2'd2)) begin
      obuf_d = sbuf_q;
    end
    if (pend_q) begin
      if (kept == 2'd0) begin
        obuf_d = fifo_rdata_i;
      end else begin
        sbuf_d = fifo_rdata_i;
      end
    end
    if (pop) begin
      wcnt_d = axis_tlast_o ? '0 : (wcnt_q + LEN_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        count_q <= 2'd0;
        pend_q  <= 1'b0;
        wcnt_q  <= '0;
        obuf_q  <= '0;
        sbuf_q  <= '0;
      end else begin
        count_q <= count_d;
        pend_q  <= pend_d;
        wcnt_q  <= wcnt_d;
        obuf_q  <= obuf_d;
        sbuf_q  <= sbuf_d;
      end
    end
  end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Bench for iob_fifo2axis: a queue-based FIFO model upstream and a word-level scoreboard downstream.
module tb_iob_fifo2axis;
  localparam int DW = 21;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          cke = 1'b1;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [LW-1:0] len = '0;
  logic          fifo_read;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [LW-1:0] word_cnt;

  always #5 clk = ~clk;

  iob_fifo2axis #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .len_i(len),
    .fifo_read_o(fifo_read), .fifo_rdata_i(fifo_rdata), .fifo_empty_i(fifo_empty),
    .axis_tdata_o(tdata), .axis_tvalid_o(tvalid), .axis_tready_i(tready),
    .axis_tlast_o(tlast), .word_cnt_o(word_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            sent = 0;
  bit            last_rd = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  int n_reads, n_pops, first_rd, first_vld, first_pop, last_pop, tl_mask, tl_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_pops = 0; first_rd = -1; first_vld = -1;
    first_pop = -1; last_pop = -1; tl_mask = 0; tl_cnt = 0;
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : DW'(base + i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock: observe at negedge, then advance the upstream FIFO and the scoreboard.
  task automatic step();
    bit rd, pp, ev, el, ol;
    int occ;
    logic [LW-1:0] ew;
    logic [DW-1:0] w;
    @(negedge clk);
    rd = fifo_read;
    pp = tvalid & tready & cke;
    ol = tlast;
    if (rst) begin
      check("read_in_reset", {63'd0, fifo_read}, 64'd0);
    end else begin
      occ = exp_q.size() - (last_rd ? 1 : 0);
      ev  = (occ > 0);
      ew  = (len == 0) ? LW'(sent) : LW'(sent % int'(len));
      el  = ev && (len != 0) && ((sent % int'(len)) == int'(len) - 1);
      check("tvalid", {63'd0, tvalid}, {63'd0, ev});
      check("word_cnt", {48'd0, word_cnt}, {48'd0, ew});
      check("tlast", {63'd0, tlast}, {63'd0, el});
      if (tvalid && occ > 0) check("tdata", {43'd0, tdata}, {43'd0, exp_q[0]});
      if (prev_stall) begin
        check("stall_tdata", {43'd0, tdata}, {43'd0, prev_data});
        check("stall_tlast", {63'd0, tlast}, {63'd0, prev_last});
      end
      if (rd) check("read_when_empty", {63'd0, fifo_empty}, 64'd0);
      if (pp) check("pop_has_data", {63'd0, exp_q.size() > 0}, 64'd1);
    end
    prev_stall = !rst && tvalid && !(tready && cke);
    prev_data  = tdata;
    prev_last  = tlast;
    if (rd && first_rd < 0) first_rd = cyc;
    if (!rst && tvalid && first_vld < 0) first_vld = cyc;
    @(posedge clk);
    #1;
    if (cke && rst) begin
      fifo_q.delete(); exp_q.delete();
      sent = 0; last_rd = 1'b0; prev_stall = 1'b0;
    end else if (cke) begin
      if (pp) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (ol) begin tl_mask |= (1 << n_pops); tl_cnt++; end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        sent++; n_pops++;
      end
      if (rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
        fifo_rdata = w;
        n_reads++;
      end
      last_rd = rd;
      check("occupancy_le_2", {63'd0, exp_q.size() <= 2}, 64'd1);
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    clear_stats();

    // Reset values and basic drain of 1,2,3
    en = 1'b1; tready = 1'b1; len = '0;
    do_reset();
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tdata", {43'd0, tdata}, 64'd0);
    check("rst_tlast", {63'd0, tlast}, 64'd0);
    check("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
    clear_stats();
    load(3, 1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("drain_latency", 64'(first_vld - first_rd), 64'd2);
    check("drain_pops", 64'(n_pops), 64'd3);
    check("drain_back_to_back", 64'(last_pop - first_pop), 64'd2);

    // Backpressure: 10 words with tready low for 10 cycles
    do_reset();
    clear_stats();
    tready = 1'b0;
    load(10, 0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("bp_reads", 64'(n_reads), 64'd2);
    check("bp_tvalid", {63'd0, tvalid}, 64'd1);
    check("bp_tdata", {43'd0, tdata}, 64'd0);
    clear_stats();
    tready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("bp_pops", 64'(n_pops), 64'd10);
    check("bp_no_gaps", 64'(last_pop - first_pop), 64'd9);
    for (int i = 0; i < 3; i++) step();

    // tlast with len=4, then never with len=0
    len = 16'd4;
    do_reset();
    clear_stats();
    load(10, 100, 1'b0);
    for (int i = 0; i < 14; i++) step();
    check("len4_pops", 64'(n_pops), 64'd10);
    check("len4_tlast_words", 64'(tl_mask), 64'd136);
    len = 16'd0;
    do_reset();
    clear_stats();
    load(10, 200, 1'b0);
    for (int i = 0; i < 14; i++) step();
    check("len0_pops", 64'(n_pops), 64'd10);
    check("len0_no_tlast", 64'(tl_cnt), 64'd0);

    // en_i dropped the cycle after a read issues
    do_reset();
    load(5, 10, 1'b0);
    en = 1'b1; tready = 1'b1;
    step();
    en = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) step();
    check("en_low_reads", 64'(n_reads), 64'd0);
    check("en_low_inflight_delivered", 64'(n_pops), 64'd1);
    en = 1'b1;
    clear_stats();
    for (int i = 0; i < 12; i++) step();
    check("en_high_rest", 64'(n_pops), 64'd4);

    // Random stall, random clock enable, 1000 random words
    len = 16'd5;
    do_reset();
    clear_stats();
    load(1000, 0, 1'b1);
    guard = 0;
    while (n_pops < 1000 && guard < 20000) begin
      tready = ($urandom_range(0, 1) == 1);
      en     = ($urandom_range(0, 9) != 0);
      cke    = ($urandom_range(0, 9) != 0);
      step();
      guard++;
    end
    cke = 1'b1; en = 1'b1;
    check("random_all_delivered", 64'(n_pops), 64'd1000);

    // Reset mid-stream with the buffer full
    len = 16'd3;
    do_reset();
    load(6, 300, 1'b0);
    tready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_full", {63'd0, tvalid}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_reset_tvalid", {63'd0, tvalid}, 64'd0);
    check("post_reset_word_cnt", {48'd0, word_cnt}, 64'd0);
    clear_stats();
    load(3, 400, 1'b0);
    tready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("restart_pops", 64'(n_pops), 64'd3);
    check("restart_reads", 64'(n_reads), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
